regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port register file; the successor to the single-write, dual-read 32x32 MIPS register file.
- Generalised data width, depth, read-port count and write-port count.
- Optional hardwired-zero register 0.
- Optional same-cycle write-to-read bypass.
- Registered write-collision flag.
- Synchronous clear on reset.
- Sits in decode/writeback: read ports feed operand fetch; write ports are driven by the writeback (and optional second) pipeline stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
NUM_WR, 2, number of write ports (1..2)
ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = a read of an address written this cycle returns the write data combinationally

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
read_address  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
read_data  out  NUM_RD*DATA_W  packed read data; port i = bits [i*DATA_W +: DATA_W]
write_en  in  NUM_WR  per-port write enable
write_address  in  NUM_WR*ADDR_W  packed write addresses
write_data  in  NUM_WR*DATA_W  packed write data
wr_collision  out  1  registered: previous cycle had 2 enabled writes to the same non-ignored address

Behaviour:
- Reset, synchronous: rst high at a rising edge clears all 2**ADDR_W entries to 0 and clears wr_collision to 0. Writes presented in that cycle are dropped.
- Reset mid-operation: a write in the reset cycle does not land. Reads during rst are combinational on current contents, so reads in the reset cycle still see old values.
- Write: on a rising edge with rst=0, each port w with write_en[w]=1 writes write_data[w] to write_address[w]. The new value is visible to non-bypassed reads from the next cycle (1-cycle write latency).
- Read: combinational, 0-cycle latency. read_data[i] = mem[read_address[i]], subject to the bypass and R0 rules.
- Read priority per read port:
  - If ZERO_R0=1 and the address is 0, return 0.
  - Else, if BYPASS=1 and an enabled write port targets the address this cycle, return the winning write's data.
  - Else, return the stored value.
- Write collision: both ports enabled with the same address.
  - The higher-numbered port (port 1) wins, for both storage and bypass.
  - wr_collision goes to 1 on the next edge and holds for one cycle per colliding cycle.
  - Address 0 with ZERO_R0=1 never flags a collision.
- ZERO_R0=1: writes to address 0 are discarded, and storage for entry 0 may be optimised out. ZERO_R0=0: entry 0 is an ordinary register.
- Write with write_en=0: no state change, regardless of address/data.
- NUM_WR=1: the collision logic is absent and wr_collision is tied to 0.
- Read ports are independent; several ports reading the same address all return the same value.
- Widths are exact: no sign extension; data is stored verbatim at DATA_W bits.

Decomposition:
- Shared package regfile_pkg:
  - default constants: DATA_W=32, ADDR_W=5.
  - function to slice a packed port bus.
  - localparam for the MIPS $zero index (0).
- Natural sub-module: regfile_read_mux, instantiated NUM_RD times. It is one read port: R0 check, bypass compare against all write ports with port-1 priority, storage mux.
- The top holds the storage array, the write decode with port priority, and the collision flag register.

Test Plan:
- Write/readback: port 0 writes 35 to addr 5, en=1 -> next cycle read port 1 at addr 5 returns 35; read port 0 at addr 3 returns 0.
- Disabled write: en=0, addr 3, data 35 -> addr 3 still reads 0 afterwards; addr 5 still reads 35.
- Zero register: ZERO_R0=1, write 0xDEADBEEF to addr 0 -> addr 0 reads 0 on all ports, including the bypassed path in the same cycle; wr_collision stays 0 when both ports also target addr 0.
- Bypass: BYPASS=1, port 0 writes 0x1234 to addr 7 while read port 0 reads addr 7 -> 0x1234 in the same cycle. BYPASS=0 -> old value that cycle, 0x1234 next cycle.
- Collision: port 0 writes 0xAAAA and port 1 writes 0x5555, both to addr 9 -> addr 9 holds 0x5555; wr_collision=1 for exactly one cycle, then 0.
- Reset: fill addrs 1..31 with their own index, assert rst one cycle alongside a write of 0x77 to addr 4 -> all addrs read 0 after the edge, addr 4 = 0 (not 0x77), wr_collision=0.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// regfile_pkg: shared constants and bus-slicing helper. Rev 1.0
// ---------------------------------------------------------------
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int ZERO_IDX       = 0;

  // LSB offset of a given port's field inside a packed multi-port bus.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_read_mux.sv
`default_nettype none
// ---------------------------------------------------------------
// regfile_read_mux: one read port (R0, bypass, storage). Rev 1.0
// ---------------------------------------------------------------
module regfile_read_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int NUM_WR  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        write_en,
  input  logic [NUM_WR*ADDR_W-1:0] write_address,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0]        stored,
  output logic [DATA_W-1:0]        data
);

  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(ZERO_IDX);

  always_comb begin
    data = stored;
    // Later ports overwrite earlier matches, giving port 1 priority.
    if (BYPASS != 0) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (write_en[w] && (write_address[port_lsb(w, ADDR_W) +: ADDR_W] == addr))
          data = write_data[port_lsb(w, DATA_W) +: DATA_W];
      end
    end
    if ((ZERO_R0 != 0) && (addr == R0))
      data = '0;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------
// regfile_mp: parametrised multi-port register file. Rev 1.0
// ---------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] read_address,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  input  logic [NUM_WR-1:0]        write_en,
  input  logic [NUM_WR*ADDR_W-1:0] write_address,
  input  logic [NUM_WR*DATA_W-1:0] write_data,
  output logic                     wr_collision
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0    = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem [DEPTH];

  // Writes are applied in port order, so port 1 lands last on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++)
        mem[e] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (write_en[w] &&
            !((ZERO_R0 != 0) && (write_address[port_lsb(w, ADDR_W) +: ADDR_W] == R0)))
          mem[write_address[port_lsb(w, ADDR_W) +: ADDR_W]] <=
            write_data[port_lsb(w, DATA_W) +: DATA_W];
      end
    end
  end

  generate
    if (NUM_WR == 2) begin : g_coll
      logic [ADDR_W-1:0] wa0;
      logic [ADDR_W-1:0] wa1;
      logic              coll_now;
      logic              coll_q;

      assign wa0 = write_address[0 +: ADDR_W];
      assign wa1 = write_address[ADDR_W +: ADDR_W];
      assign coll_now = write_en[0] && write_en[1] && (wa0 == wa1) &&
                        !((ZERO_R0 != 0) && (wa0 == R0));

      always_ff @(posedge clk) begin
        if (rst) coll_q <= 1'b0;
        else     coll_q <= coll_now;
      end

      assign wr_collision = coll_q;
    end else begin : g_no_coll
      assign wr_collision = 1'b0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = read_address[port_lsb(i, ADDR_W) +: ADDR_W];

      regfile_read_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR),
        .ZERO_R0(ZERO_R0),
        .BYPASS (BYPASS)
      ) u_rd (
        .addr         (ra),
        .write_en     (write_en),
        .write_address(write_address),
        .write_data   (write_data),
        .stored       (mem[ra]),
        .data         (read_data[port_lsb(i, DATA_W) +: DATA_W])
      );
    end
  endgenerate

endmodule
`default_nettype wire
